// File: rtl/hamming_secded_rx.sv
// Serial receive stage for extended Hamming(8,4) SECDED codewords: assembles LSB-first frames,
// corrects single-bit errors, flags double-bit errors and keeps saturating error counts.
module hamming_secded_rx #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             ser_sof,
  output logic             ser_ready,
  output logic [3:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_corr,
  output logic             out_uncorr,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  typedef enum logic [1:0] {COLLECT, DECODE, OUTPUT} state_t;

  state_t           state, state_nxt;
  logic [7:0]       cw_p0;
  logic [2:0]       bitcnt_p0;
  logic [3:0]       data_p1;
  logic             corr_p1, uncorr_p1;
  logic [CNT_W-1:0] corr_cnt_q, uncorr_cnt_q;
  logic             accept;
  logic [5:0]       dec;

  // Returns {corr, uncorr, data[3:0]}; an uncorrectable frame passes its raw data bits through.
  function automatic logic [5:0] secded_decode(input logic [7:0] c);
    logic [2:0] syn;
    logic       par;
    logic [7:0] fixed;
    syn   = {c[3] ^ c[4] ^ c[5] ^ c[6],
             c[1] ^ c[2] ^ c[5] ^ c[6],
             c[0] ^ c[2] ^ c[4] ^ c[6]};
    par   = ^c;
    fixed = c;
    if (par && (syn != 3'd0))
      fixed[syn - 3'd1] = ~c[syn - 3'd1];
    return {par, (~par) & (syn != 3'd0), fixed[6], fixed[5], fixed[4], fixed[2]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign accept = ser_valid && (state == COLLECT);
  assign dec    = secded_decode(cw_p0);

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (accept && !ser_sof && (bitcnt_p0 == 3'd7)) state_nxt = DECODE;
      DECODE:  state_nxt = OUTPUT;
      OUTPUT:  if (out_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // Stage p0: serial bit collection; a start-of-frame bit restarts the frame at c[0]
  always_ff @(posedge clk) begin
    if (rst) begin
      cw_p0     <= 8'd0;
      bitcnt_p0 <= 3'd0;
    end else if (accept) begin
      if (ser_sof) begin
        cw_p0     <= {7'd0, ser_in};
        bitcnt_p0 <= 3'd1;
      end else begin
        cw_p0[bitcnt_p0] <= ser_in;
        bitcnt_p0        <= bitcnt_p0 + 3'd1;
      end
    end
  end

  // Stage p1: decoded nibble and flags, held through OUTPUT until the handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1   <= 4'd0;
      corr_p1   <= 1'b0;
      uncorr_p1 <= 1'b0;
    end else if (state == DECODE) begin
      {corr_p1, uncorr_p1, data_p1} <= dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (state == DECODE) begin
      if (dec[5]) corr_cnt_q   <= sat_inc(corr_cnt_q);
      if (dec[4]) uncorr_cnt_q <= sat_inc(uncorr_cnt_q);
    end
  end

  assign ser_ready  = (state == COLLECT);
  assign out_valid  = (state == OUTPUT);
  assign out_data   = data_p1;
  assign out_corr   = corr_p1;
  assign out_uncorr = uncorr_p1;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_secded_rx.sv
// Directed table-driven bench for hamming_secded_rx plus hand-written sequences for
// backpressure, frame restart, reset, counter saturation and counter clear.
module tb_hamming_secded_rx;

  logic       clk = 1'b0;
  logic       rst, ser_in, ser_valid, ser_sof, ser_ready;
  logic [3:0] out_data;
  logic       out_valid, out_ready, out_corr, out_uncorr, cnt_clr;
  logic [7:0] corr_cnt, uncorr_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_corr_cnt   = 0;
  int exp_uncorr_cnt = 0;

  typedef struct {
    logic [7:0] cw;
    logic [3:0] data;
    logic       corr;
    logic       uncorr;
  } vec_t;

  vec_t vecs[8];

  hamming_secded_rx #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .ser_sof(ser_sof),
    .ser_ready(ser_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_corr(out_corr), .out_uncorr(out_uncorr), .cnt_clr(cnt_clr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] cw, input int n);
    for (int i = 0; i < n; i++) begin
      ser_valid = 1'b1;
      ser_in    = cw[i];
      ser_sof   = (i == 0);
      tick();
    end
    ser_valid = 1'b0;
    ser_sof   = 1'b0;
    ser_in    = 1'b0;
  endtask

  // Called right after the 8th bit edge with out_ready=1; walks DECODE, OUTPUT, back to COLLECT.
  task automatic expect_frame(input string name, input logic [3:0] d, input logic c, input logic u);
    check({name, "_decode_valid"}, out_valid, 0);
    check({name, "_decode_ready"}, ser_ready, 0);
    tick();
    if (c) exp_corr_cnt   = (exp_corr_cnt   == 255) ? 255 : exp_corr_cnt + 1;
    if (u) exp_uncorr_cnt = (exp_uncorr_cnt == 255) ? 255 : exp_uncorr_cnt + 1;
    check({name, "_valid"}, out_valid, 1);
    check({name, "_data"}, out_data, d);
    check({name, "_corr"}, out_corr, c);
    check({name, "_uncorr"}, out_uncorr, u);
    check({name, "_corr_cnt"}, corr_cnt, exp_corr_cnt);
    check({name, "_uncorr_cnt"}, uncorr_cnt, exp_uncorr_cnt);
    tick();
    check({name, "_ready_back"}, ser_ready, 1);
    check({name, "_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    vecs[0] = '{8'h55, 4'b1011, 1'b0, 1'b0};
    vecs[1] = '{8'h45, 4'b1011, 1'b1, 1'b0};
    vecs[2] = '{8'hD5, 4'b1011, 1'b1, 1'b0};
    vecs[3] = '{8'h56, 4'b1011, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 4'b0000, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 4'b1111, 1'b0, 1'b0};
    vecs[6] = '{8'h83, 4'b0001, 1'b1, 1'b0};
    vecs[7] = '{8'hE7, 4'b1101, 1'b0, 1'b1};

    rst = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; ser_sof = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_ready", ser_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_flags", {out_corr, out_uncorr}, 0);
    check("rst_cnts", {corr_cnt, uncorr_cnt}, 0);

    for (int i = 0; i < 8; i++) begin
      send_bits(vecs[i].cw, 8);
      expect_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].corr, vecs[i].uncorr);
    end

    // Backpressure: output held, serial bits ignored while not ready
    out_ready = 1'b0;
    send_bits(8'h55, 8);
    tick();
    for (int k = 0; k < 5; k++) begin
      ser_valid = 1'b1; ser_sof = 1'b1; ser_in = 1'b1;
      check("hold_ready", ser_ready, 0);
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, 4'b1011);
      tick();
    end
    ser_valid = 1'b0; ser_sof = 1'b0; ser_in = 1'b0;
    check("hold_data_end", out_data, 4'b1011);
    out_ready = 1'b1;
    tick();
    check("hold_release_ready", ser_ready, 1);
    check("hold_release_valid", out_valid, 0);

    // Partial frame discarded by a new start-of-frame
    send_bits(8'hFF, 3);
    send_bits(8'h00, 8);
    expect_frame("restart", 4'b0000, 1'b0, 1'b0);

    // Reset mid-frame
    send_bits(8'hFF, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_corr_cnt = 0; exp_uncorr_cnt = 0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_flags", {out_corr, out_uncorr}, 0);
    check("mid_rst_cnts", {corr_cnt, uncorr_cnt}, 0);
    check("mid_rst_ready", ser_ready, 1);
    send_bits(8'h55, 8);
    expect_frame("post_rst", 4'b1011, 1'b0, 1'b0);

    // Reset during OUTPUT
    out_ready = 1'b0;
    send_bits(8'h45, 8);
    tick();
    check("out_rst_pre_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    check("out_rst_valid", out_valid, 0);
    check("out_rst_corr", out_corr, 0);
    check("out_rst_cnt", corr_cnt, 0);
    exp_corr_cnt = 0; exp_uncorr_cnt = 0;

    // Saturation of the corrected-frame counter
    for (int n = 0; n < 256; n++) begin
      send_bits(8'h45, 8);
      tick(); tick();
    end
    check("sat_corr_cnt", corr_cnt, 255);
    check("sat_uncorr_cnt", uncorr_cnt, 0);
    exp_corr_cnt = 255;
    send_bits(8'h45, 8);
    expect_frame("sat_hold", 4'b1011, 1'b1, 1'b0);

    // Clear wins over a simultaneous increment in DECODE
    send_bits(8'h56, 8);
    expect_frame("pre_clr", 4'b1011, 1'b0, 1'b1);
    send_bits(8'h45, 8);
    check("clr_in_decode", out_valid, 0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_corr_cnt", corr_cnt, 0);
    check("clr_uncorr_cnt", uncorr_cnt, 0);
    check("clr_flag", out_corr, 1);
    tick();
    check("clr_ready_back", ser_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
